// File: rtl/mcu_pkg.sv
// ---------------------------------------------------------------------------
// mcu_pkg
// Shared definitions for the MCU interrupt scheduler: default PC width,
// default vector table placement, cause-id width and the scheduler FSM
// state encoding.
// ---------------------------------------------------------------------------
package mcu_pkg;

  // Default program-counter width of the MCU core.
  localparam int PC_W_DEF = 11;

  // Width of a source id (up to 8 sources).
  localparam int CAUSE_W = 3;

  // Default vector table: source 0 at 0x004, one slot every 4 words.
  localparam logic [PC_W_DEF-1:0] VEC_BASE_DEF   = 11'h004;
  localparam int                  VEC_STRIDE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_e;

endpackage

// File: rtl/mcu_irq_prio.sv
// ---------------------------------------------------------------------------
// mcu_irq_prio
// Combinational fixed-priority encoder: the lowest-indexed set bit of
// eligible_i wins.
// Ports:
//   eligible_i  in  N_SRC    pending & mask
//   any_o       out 1        at least one source eligible
//   id_o        out CAUSE_W  index of the winning source (0 when none)
// ---------------------------------------------------------------------------
module mcu_irq_prio
  import mcu_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]   eligible_i,
  output logic               any_o,
  output logic [CAUSE_W-1:0] id_o
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    any_o = 1'b0;
    id_o  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        any_o = 1'b1;
        id_o  = CAUSE_W'(i);
      end
    end
  end

endmodule

// File: rtl/mcu_irq_ctrl.sv
// ---------------------------------------------------------------------------
// mcu_irq_ctrl
// Interrupt scheduler for the pipelined MCU core. Captures rising edges on
// the interrupt sources, holds them pending, picks one by fixed priority,
// waits for an instruction boundary, then pulses flush with the handler
// vector. Tracks the in-service handler until RETFIE; no nesting.
// Ports:
//   clk, reset            clock / asynchronous active-high reset
//   irq_src               source levels, rising edge = request
//   mask_wr, mask_din     load per-source enable mask
//   gie_wr, gie_din       load global interrupt enable
//   pend_clr              software clear of pending bits
//   pipe_ready            CPU at an instruction boundary
//   retfie                RETFIE retiring in EX (1-cycle pulse)
//   ret_pc                resume address of the next un-retired instruction
//   irq_req               request waiting for pipe_ready
//   flush, vec_valid      1-cycle pulse: squash IF/ID and jump to vec_pc
//   vec_pc                handler vector (valid with vec_valid, else 0)
//   saved_pc              resume address captured at grant
//   cause                 id of granted / in-service source
//   pending, gie          pending register / global enable register
//   in_service            handler active
// ---------------------------------------------------------------------------
module mcu_irq_ctrl
  import mcu_pkg::*;
#(
  parameter int              N_SRC      = 4,
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(VEC_BASE_DEF),
  parameter int              VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    irq_src,
  input  logic                mask_wr,
  input  logic [N_SRC-1:0]    mask_din,
  input  logic                gie_wr,
  input  logic                gie_din,
  input  logic [N_SRC-1:0]    pend_clr,
  input  logic                pipe_ready,
  input  logic                retfie,
  input  logic [PC_W-1:0]     ret_pc,
  output logic                irq_req,
  output logic                flush,
  output logic                vec_valid,
  output logic [PC_W-1:0]     vec_pc,
  output logic [PC_W-1:0]     saved_pc,
  output logic [CAUSE_W-1:0]  cause,
  output logic [N_SRC-1:0]    pending,
  output logic                gie,
  output logic                in_service
);

  localparam logic [PC_W-1:0] STRIDE_PC = PC_W'(VEC_STRIDE);

  irq_state_e          state_q, state_d;
  logic [N_SRC-1:0]    src_q;
  logic [N_SRC-1:0]    pending_q, pending_d;
  logic [N_SRC-1:0]    mask_q, mask_d;
  logic                gie_q, gie_d;
  logic [PC_W-1:0]     saved_pc_q, saved_pc_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;

  logic [N_SRC-1:0]    rise;
  logic [N_SRC-1:0]    eligible;
  logic [N_SRC-1:0]    cause_oh;
  logic [N_SRC-1:0]    grant_clr;
  logic                win_any;
  logic [CAUSE_W-1:0]  win_id;
  logic                latched_ok;
  logic                grant;

  mcu_irq_prio #(
    .N_SRC (N_SRC)
  ) u_prio (
    .eligible_i (eligible),
    .any_o      (win_any),
    .id_o       (win_id)
  );

  assign rise     = irq_src & ~src_q;
  assign eligible = pending_q & mask_q;
  assign cause_oh = N_SRC'(1) << cause_q;

  // The source latched on entry to REQ must still be eligible at grant time;
  // otherwise REQ is abandoned without side effects.
  assign latched_ok = |(eligible & cause_oh);
  assign grant      = (state_q == ST_REQ) && gie_q && latched_ok && pipe_ready;
  assign grant_clr  = grant ? cause_oh : '0;

  // A new edge wins over a same-cycle software or grant clear.
  assign pending_d = (pending_q & ~pend_clr & ~grant_clr) | rise;
  assign mask_d    = mask_wr ? mask_din : mask_q;

  // Hardware updates (grant, return) override a same-cycle software write.
  always_comb begin
    gie_d = gie_q;
    if (gie_wr) gie_d = gie_din;
    if (grant) gie_d = 1'b0;
    if ((state_q == ST_SERVICE) && retfie) gie_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    saved_pc_d = saved_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gie_q && win_any) begin
          state_d = ST_REQ;
          cause_d = win_id;
        end
      end
      ST_REQ: begin
        if (!gie_q || !latched_ok) begin
          state_d = ST_IDLE;
        end else if (pipe_ready) begin
          state_d    = ST_FLUSH;
          saved_pc_d = ret_pc;
        end
      end
      ST_FLUSH: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        // Returning to IDLE guarantees one idle cycle before the next REQ.
        if (retfie) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      saved_pc_q <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= irq_src;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      saved_pc_q <= saved_pc_d;
      cause_q    <= cause_d;
    end
  end

  // Outputs decode straight from state so reset drops flush asynchronously.
  assign irq_req    = (state_q == ST_REQ);
  assign flush      = (state_q == ST_FLUSH);
  assign vec_valid  = flush;
  assign vec_pc     = flush ? (VEC_BASE + PC_W'(cause_q) * STRIDE_PC) : '0;
  assign in_service = (state_q == ST_SERVICE);
  assign saved_pc   = saved_pc_q;
  assign cause      = cause_q;
  assign pending    = pending_q;
  assign gie        = gie_q;

endmodule
